// File: rtl/buffer_reader_pkg.sv
// Shared configuration for the buffer read-side stream controller.
package buffer_reader_pkg;

  localparam int STREAM_DWIDTH = 16;
  localparam int BURST_LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry in-order queue; the head entry is always visible on head_data.
module skid_fifo2
  import buffer_reader_pkg::*;
#(
  parameter int DWIDTH = STREAM_DWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic              full,
  output logic              empty
);

  logic [DWIDTH-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == 2'd2);
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/buffer_reader.sv
// Drains a fixed-length burst from a preloaded buffer and presents it as a
// valid/ready stream with a last flag, absorbing the buffer's read latency.
module buffer_reader
  import buffer_reader_pkg::*;
#(
  parameter int DWIDTH = STREAM_DWIDTH,
  parameter int LEN_W  = BURST_LEN_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  input  logic [DWIDTH-1:0] buf_dout,
  input  logic              buf_empty,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_last
);

  rd_state_e        state;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] acc_cnt;
  logic             capture;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             issue;
  logic             credit;
  logic [1:0]       occupancy;

  // Occupancy counts queued words plus the read still in flight, so a new
  // read is only issued when its data is guaranteed a free slot on arrival.
  assign occupancy = (fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1)) + {1'b0, capture};
  assign m_valid   = !fifo_empty;
  assign pop       = m_valid && m_ready;
  assign credit    = (occupancy < 2'd2) || ((occupancy == 2'd2) && pop);
  assign buf_rd_en = (state == STREAM) && (issue_cnt != '0) && credit;
  assign issue     = buf_rd_en && !buf_empty;
  assign m_last    = m_valid && (acc_cnt == LEN_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      capture   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      capture <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              issue_cnt <= len;
              acc_cnt   <= len;
              state     <= STREAM;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (issue) begin
            issue_cnt <= issue_cnt - LEN_W'(1);
          end
          if (pop) begin
            acc_cnt <= acc_cnt - LEN_W'(1);
            if (acc_cnt == LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  skid_fifo2 #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (capture),
    .push_data (buf_dout),
    .pop       (pop),
    .head_data (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_buffer_reader.sv
// Self-checking bench for buffer_reader: buffer model, burst-level reference
// model and one per-cycle compare process.
module tb_buffer_reader;
  import buffer_reader_pkg::*;

  localparam int DW = STREAM_DWIDTH;
  localparam int LW = BURST_LEN_W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          buf_rd_en;
  logic [DW-1:0] buf_dout = '0;
  logic          buf_empty;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;

  buffer_reader #(
    .DWIDTH(DW),
    .LEN_W (LW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .buf_rd_en (buf_rd_en),
    .buf_dout  (buf_dout),
    .buf_empty (buf_empty),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  // Buffer model: contents staged in mem, wr_ptr marks what is visible.
  int mem [1024];
  int rd_ptr = 0;
  int wr_ptr = 0;
  bit rd_issue = 1'b0;

  assign buf_empty = (rd_ptr == wr_ptr);

  always @(negedge clk) rd_issue = buf_rd_en && !buf_empty;

  always @(posedge clk) begin
    if (rd_issue) begin
      buf_dout <= DW'(mem[rd_ptr]);
      rd_ptr   <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  int test_id = 0;
  int drip_left = 0;
  bit final_req = 1'b0;
  bit final_done = 1'b0;

  // Reference model state
  int  c = 0;
  int  done_at = -1;
  bit  burst_on = 1'b0;
  int  rem = 0;
  int  blen = 0;
  int  issued = 0;
  int  popped = 0;
  int  acc_cyc = 0;
  int  tid_b = 0;
  int  exp_q[$];
  bit  hold_v = 1'b0;
  int  hold_d = 0;
  int  hold_l = 0;
  int  rd_first, rd_last, rd_cnt, v_first, v_last, v_cnt, hs_cnt, b_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, c);
    end
  endtask

  always @(negedge clk) begin
    bit idle_now;
    bit hs;
    bit iss;
    int rel;
    if (!rstn) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", buf_rd_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_last", m_last, 0);
      chk("rst_data", m_data, 0);
      burst_on = 1'b0;
      done_at  = -1;
      hold_v   = 1'b0;
      exp_q.delete();
    end else begin
      idle_now = !burst_on && (c != done_at);
      hs  = m_valid && m_ready;
      iss = buf_rd_en && !buf_empty;

      chk("done", done, c == done_at);
      chk("busy", busy, burst_on || (c == done_at));
      if (!burst_on) begin
        chk("idle_valid", m_valid, 0);
        chk("idle_rd_en", buf_rd_en, 0);
      end
      if (hold_v) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, hold_d);
        chk("stall_last", m_last, hold_l);
      end
      if (burst_on && m_valid) chk("last", m_last, rem == 1);
      if (burst_on && hs) chk("data", m_data, exp_q[0]);

      if (burst_on || (c == done_at)) begin
        rel = c - acc_cyc;
        if (buf_rd_en) begin
          if (rd_first < 0) rd_first = rel;
          rd_last = rel;
          rd_cnt++;
        end
        if (m_valid) begin
          if (v_first < 0) v_first = rel;
          v_last = rel;
          v_cnt++;
        end
        if (busy) b_cnt++;
        if (hs) hs_cnt++;
      end

      if (c == done_at) begin
        rel = c - acc_cyc;
        case (tid_b)
          1: begin
            chk("t1_rd_first", rd_first, 1);
            chk("t1_rd_last", rd_last, 8);
            chk("t1_rd_cnt", rd_cnt, 8);
            chk("t1_valid_first", v_first, 3);
            chk("t1_valid_last", v_last, 10);
            chk("t1_valid_cnt", v_cnt, 8);
            chk("t1_handshakes", hs_cnt, 8);
            chk("t1_done_cycle", rel, 11);
          end
          2: chk("t2_handshakes", hs_cnt, 4);
          3: chk("t3_handshakes", hs_cnt, 5);
          4: begin
            chk("t4_rd_cnt", rd_cnt, 0);
            chk("t4_valid_cnt", v_cnt, 0);
            chk("t4_busy_cycles", b_cnt, 1);
            chk("t4_done_cycle", rel, 1);
          end
          5: chk("t5_handshakes", hs_cnt, 8);
          6: chk("t6_handshakes", hs_cnt, 2);
          default: ;
        endcase
      end

      if (burst_on && hs) begin
        void'(exp_q.pop_front());
        rem--;
        popped++;
        if (rem == 0) begin
          burst_on = 1'b0;
          done_at  = c + 1;
        end
      end
      if (iss) begin
        issued++;
        chk("outstanding_le2", (issued - popped) <= 2, 1);
        chk("issue_le_len", issued <= blen, 1);
      end
      hold_v = m_valid && !m_ready;
      hold_d = int'(m_data);
      hold_l = int'(m_last);

      if (idle_now && start) begin
        acc_cyc = c;
        tid_b   = test_id;
        rd_first = -1; rd_last = -1; rd_cnt = 0;
        v_first  = -1; v_last  = -1; v_cnt  = 0;
        hs_cnt = 0; b_cnt = 0;
        issued = 0; popped = 0;
        blen = int'(len);
        if (len == '0) begin
          done_at = c + 1;
        end else begin
          burst_on = 1'b1;
          rem = int'(len);
          exp_q.delete();
          for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[rd_ptr + i]);
        end
      end

      if (final_req && !final_done) begin
        chk("timeouts", timeouts, 0);
        final_done = 1'b1;
      end
    end
    c++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++)
      mem[wr_ptr + i] = rnd ? int'($urandom_range(0, 65535)) : base + i;
  endtask

  task automatic avail(input int n);
    wr_ptr += n;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = LW'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int mode, input bit junk, input int max);
    bit got = 1'b0;
    for (int k = 0; k < max; k++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (k % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      start = junk && ($urandom_range(0, 6) == 0);
      len   = LW'($urandom_range(0, 255));
      if (drip_left > 0 && $urandom_range(0, 2) == 0) begin
        wr_ptr++;
        drip_left--;
      end
      tick();
    end
    if (!got) timeouts++;
    start   = 1'b0;
    m_ready = 1'b1;
    tick();
  endtask

  initial begin
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();

    test_id = 1; fill(8, 0, 1); avail(8); m_ready = 1'b1;
    do_start(8); wait_done(0, 0, 100);

    test_id = 2; fill(4, 0, 1); avail(4);
    do_start(4); wait_done(1, 0, 100);

    test_id = 3; fill(5, 0, 1); avail(2); m_ready = 1'b1;
    do_start(5); repeat (5) tick(); avail(3); wait_done(0, 0, 100);

    test_id = 4; do_start(0); wait_done(0, 0, 20);

    test_id = 5; fill(8, 0, 1); avail(8);
    do_start(8); repeat (3) tick();
    start = 1'b1; len = LW'(3); tick(); start = 1'b0;
    wait_done(0, 0, 100);

    test_id = 6; fill(10, 0, 1); avail(10);
    do_start(8); repeat (4) tick();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    do_start(2); wait_done(0, 0, 50);

    test_id = 7;
    for (int b = 0; b < 8; b++) begin
      int l;
      int n0;
      l  = int'($urandom_range(1, 24));
      n0 = int'($urandom_range(0, l));
      fill(l, 1, 0);
      avail(n0);
      drip_left = l - n0;
      do_start(l);
      wait_done(2, 1, 400);
    end

    final_req = 1'b1;
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
